// File: rtl/imem_boot_loader.sv
// Boot loader: receives a byte stream (16-bit word count, then little-endian
// 32-bit words), writes each word into instruction memory and releases the
// core from reset once the whole image is written. Images larger than the
// instruction memory are rejected and the core stays in reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HDR_LO   | waiting for low byte of word count N
// HDR_HI   | waiting for high byte of N; decides DONE / ERR / DATA
// DATA     | collecting the four bytes of the next word
// WRITE    | one-cycle memory write strobe; no byte accepted
// DONE     | image loaded, core released (terminal until reset)
// ERR      | image too large, core held in reset (terminal until reset)
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Capacity in words, widened so N = 2^16-1 compares correctly.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  core_rst_q, core_rst_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [1:0]            idx_q, idx_d;
    logic [15:0]           n_q, n_d;
    logic [31:0]           word_q, word_d;
    logic [15:0]           n_full;
    logic                  xfer;

    // Next-state and next-output computation; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        word_count_d = word_count_q;
        idx_d        = idx_q;
        n_d          = n_q;
        word_d       = word_q;
        n_full       = {in_data, n_q[7:0]};
        xfer         = in_valid && in_ready_q;

        case (state_q)
            S_HDR_LO: begin
                if (xfer) begin
                    n_d[7:0] = in_data;
                    state_d  = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    n_d[15:8] = in_data;
                    if (n_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, n_full} > CAPACITY) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d      = S_WRITE;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = word_d;
                    end
                end
            end
            S_WRITE: begin
                word_count_d = word_count_q + 1'b1;
                if (17'(word_count_d) == {1'b0, n_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_HDR_LO;
        endcase

        in_ready_d  = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) || (state_d == S_DATA);
        core_rst_d  = (state_d == S_DONE);
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERR);
    end

    // State and registered outputs; reset drops core_rst immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_HDR_LO;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            word_count_q <= word_count_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            word_q       <= word_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a default-size loader (A, 1024 words) and a
// 16-word loader (B) share one input stream; the stream follows A's in_ready.
module tb_imem_boot_loader;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        a_in_ready, a_we, a_core_rst, a_done, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [10:0] a_wc;
    logic        b_in_ready, b_we, b_core_rst, b_done, b_err;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [4:0]  b_wc;

    int checks = 0;
    int fails  = 0;
    int viol   = 0;

    logic [9:0]  a_addr_log[$];
    logic [31:0] a_data_log[$];
    logic [3:0]  b_addr_log[$];
    logic [31:0] b_data_log[$];

    imem_boot_loader #(.ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .imem_we(a_we), .imem_addr(a_addr),
        .imem_wdata(a_wdata), .core_rst(a_core_rst), .load_done(a_done),
        .load_err(a_err), .word_count(a_wc)
    );

    imem_boot_loader #(.ADDR_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .core_rst(b_core_rst), .load_done(b_done),
        .load_err(b_err), .word_count(b_wc)
    );

    always #5 clk = ~clk;

    // Write logger; a write cycle must never also offer in_ready.
    always @(negedge clk) begin
        if (rst) begin
            if (a_we === 1'b1) begin
                a_addr_log.push_back(a_addr);
                a_data_log.push_back(a_wdata);
                if (a_in_ready !== 1'b0) viol++;
            end
            if (b_we === 1'b1) begin
                b_addr_log.push_back(b_addr);
                b_data_log.push_back(b_wdata);
                if (b_in_ready !== 1'b0) viol++;
            end
        end
    end

    // Reference: expected write count and final status for a given capacity.
    task automatic model(input bytes_t bs, input int cap, output int nw,
                         output bit done, output bit err);
        int n;
        nw = 0; done = 0; err = 0;
        if (bs.size() >= 2) begin
            n = int'(bs[0]) + 256 * int'(bs[1]);
            if (n == 0) done = 1;
            else if (n > cap) err = 1;
            else begin
                nw = (bs.size() - 2) / 4;
                if (nw > n) nw = n;
                done = (nw == n);
            end
        end
    endtask

    function automatic logic [31:0] model_word(input bytes_t bs, input int i);
        return {bs[5+4*i], bs[4+4*i], bs[3+4*i], bs[2+4*i]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        a_addr_log.delete(); a_data_log.delete();
        b_addr_log.delete(); b_data_log.delete();
        viol = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (a_in_ready !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                checks++; fails++;
                $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", a_in_ready, t);
                break;
            end
        end
        @(posedge clk);
    endtask

    // gap_mode: 0 continuous, 1 random gaps 0..3, 2 fixed 2-cycle gaps.
    task automatic send_stream(input bytes_t bs, input int gap_mode, input bit junk);
        int g;
        foreach (bs[i]) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? int'($urandom_range(3, 0)) : 2;
            send_byte(bs[i], (i == 0) ? 0 : g);
        end
        @(negedge clk);
        in_valid = junk;
        in_data  = 8'($urandom);
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_word();
        bytes_t bs = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        do_reset();
        send_stream(bs, 0, 1'b1);
        checks++;
        if (a_addr_log.size() !== 2) begin
            fails++; $display("FAIL two_word_count: writes=%0d required 2", a_addr_log.size());
        end else begin
            checks += 4;
            if (a_addr_log[0] !== 10'd0) begin fails++; $display("FAIL two_word_addr0: got %0d required 0", a_addr_log[0]); end
            if (a_data_log[0] !== 32'h00500513) begin fails++; $display("FAIL two_word_data0: got %h required 00500513", a_data_log[0]); end
            if (a_addr_log[1] !== 10'd1) begin fails++; $display("FAIL two_word_addr1: got %0d required 1", a_addr_log[1]); end
            if (a_data_log[1] !== 32'h00A00593) begin fails++; $display("FAIL two_word_data1: got %h required 00a00593", a_data_log[1]); end
        end
        checks += 4;
        if (a_core_rst !== 1'b1 || a_done !== 1'b1 || a_err !== 1'b0) begin
            fails++; $display("FAIL two_word_status: core_rst=%b done=%b err=%b required 1 1 0", a_core_rst, a_done, a_err);
        end
        if (a_wc !== 11'd2) begin fails++; $display("FAIL two_word_wc: got %0d required 2", a_wc); end
        if (b_addr_log.size() !== 2 || b_done !== 1'b1) begin
            fails++; $display("FAIL two_word_small: writes=%0d done=%b required 2 1", b_addr_log.size(), b_done);
        end
        if (viol !== 0) begin fails++; $display("FAIL two_word_ready_in_write: %0d cycles, required 0", viol); end
    endtask

    task automatic test_reset();
        checks++;
        if (a_core_rst !== 1'b1) begin fails++; $display("FAIL reset_pre: core_rst=%b required 1", a_core_rst); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (a_in_ready !== 1'b1 || a_we !== 1'b0 || a_addr !== 10'd0 || a_wdata !== 32'd0) begin
            fails++; $display("FAIL reset_if: ready=%b we=%b addr=%0d wdata=%h required 1 0 0 0", a_in_ready, a_we, a_addr, a_wdata);
        end
        if (a_core_rst !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0 || a_wc !== 11'd0) begin
            fails++; $display("FAIL reset_status: core_rst=%b done=%b err=%b wc=%0d required 0 0 0 0", a_core_rst, a_done, a_err, a_wc);
        end
        if (b_in_ready !== 1'b1 || b_core_rst !== 1'b0 || b_wc !== 5'd0) begin
            fails++; $display("FAIL reset_small: ready=%b core_rst=%b wc=%0d required 1 0 0", b_in_ready, b_core_rst, b_wc);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_empty();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        checks++;
        if (a_done !== 1'b1 || a_core_rst !== 1'b1 || a_in_ready !== 1'b0) begin
            fails++; $display("FAIL empty_done_latency: done=%b core_rst=%b ready=%b required 1 1 0", a_done, a_core_rst, a_in_ready);
        end
        in_data = 8'h5A;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (a_addr_log.size() !== 0 || b_addr_log.size() !== 0 || a_wc !== 11'd0) begin
            fails++; $display("FAIL empty_writes: writes=%0d/%0d wc=%0d required 0 0 0", a_addr_log.size(), b_addr_log.size(), a_wc);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        in_data = 8'hC3;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        checks += 2;
        if (b_err !== 1'b1 || b_core_rst !== 1'b0 || b_done !== 1'b0 || b_in_ready !== 1'b0) begin
            fails++; $display("FAIL overflow_status: err=%b core_rst=%b done=%b ready=%b required 1 0 0 0", b_err, b_core_rst, b_done, b_in_ready);
        end
        if (b_addr_log.size() !== 0 || b_wc !== 5'd0) begin
            fails++; $display("FAIL overflow_writes: writes=%0d wc=%0d required 0 0", b_addr_log.size(), b_wc);
        end
    endtask

    task automatic test_full_memory();
        bytes_t bs;
        bs.push_back(8'h10); bs.push_back(8'h00);
        repeat (64) bs.push_back(8'($urandom));
        do_reset();
        send_stream(bs, 0, 1'b1);
        checks++;
        if (b_addr_log.size() !== 16) begin
            fails++; $display("FAIL full_count: writes=%0d required 16", b_addr_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (b_addr_log[i] !== 4'(i) || b_data_log[i] !== model_word(bs, i)) begin
                    fails++; $display("FAIL full_word%0d: addr=%0d data=%h required %0d %h", i, b_addr_log[i], b_data_log[i], i, model_word(bs, i));
                end
            end
        end
        checks++;
        if (b_done !== 1'b1 || b_err !== 1'b0 || b_core_rst !== 1'b1 || b_wc !== 5'd16) begin
            fails++; $display("FAIL full_status: done=%b err=%b core_rst=%b wc=%0d required 1 0 1 16", b_done, b_err, b_core_rst, b_wc);
        end
    endtask

    task automatic test_stall();
        bytes_t bs = '{8'h01, 8'h00, 8'h37, 8'h41, 8'h2C, 8'h9E};
        do_reset();
        send_stream(bs, 2, 1'b1);
        checks++;
        if (a_addr_log.size() !== 1) begin
            fails++; $display("FAIL stall_count: writes=%0d required 1", a_addr_log.size());
        end else begin
            checks++;
            if (a_addr_log[0] !== 10'd0 || a_data_log[0] !== 32'h9E2C4137) begin
                fails++; $display("FAIL stall_word: addr=%0d data=%h required 0 9e2c4137", a_addr_log[0], a_data_log[0]);
            end
        end
        checks += 2;
        if (a_done !== 1'b1 || a_wc !== 11'd1) begin fails++; $display("FAIL stall_status: done=%b wc=%0d required 1 1", a_done, a_wc); end
        if (viol !== 0) begin fails++; $display("FAIL stall_ready_in_write: %0d cycles, required 0", viol); end
    endtask

    task automatic test_reset_mid_word();
        bytes_t bs = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_wc !== 11'd0 || a_done !== 1'b0 || a_core_rst !== 1'b0) begin
            fails++; $display("FAIL midword_reset: ready=%b wc=%0d done=%b core_rst=%b required 1 0 0 0", a_in_ready, a_wc, a_done, a_core_rst);
        end
        @(negedge clk);
        rst = 1'b1;
        send_stream(bs, 0, 1'b1);
        checks += 2;
        if (a_addr_log.size() !== 1 || a_addr_log[0] !== 10'd0 || a_data_log[0] !== 32'hDDCCBBAA) begin
            fails++; $display("FAIL midword_reload: writes=%0d data=%h required 1 ddccbbaa", a_addr_log.size(),
                              (a_data_log.size() > 0) ? a_data_log[0] : 32'h0);
        end
        if (b_addr_log.size() !== 1 || b_data_log[0] !== 32'hDDCCBBAA || b_done !== 1'b1) begin
            fails++; $display("FAIL midword_reload_small: writes=%0d done=%b required 1 1", b_addr_log.size(), b_done);
        end
    endtask

    task automatic test_random();
        bytes_t bs;
        int n, nw_a, nw_b;
        bit done_a, err_a, done_b, err_b;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(24, 1));
            bs.delete();
            bs.push_back(8'(n)); bs.push_back(8'(n >> 8));
            repeat (4 * n) bs.push_back(8'($urandom));
            model(bs, 1024, nw_a, done_a, err_a);
            model(bs, 16, nw_b, done_b, err_b);
            do_reset();
            send_stream(bs, 1, 1'b1);
            checks += 2;
            if (a_addr_log.size() !== nw_a || a_wc !== 11'(nw_a)) begin
                fails++; $display("FAIL rand%0d_a_count: writes=%0d wc=%0d required %0d", it, a_addr_log.size(), a_wc, nw_a);
            end else begin
                for (int i = 0; i < nw_a; i++) begin
                    checks++;
                    if (a_addr_log[i] !== 10'(i) || a_data_log[i] !== model_word(bs, i)) begin
                        fails++; $display("FAIL rand%0d_a_word%0d: addr=%0d data=%h required %0d %h", it, i, a_addr_log[i], a_data_log[i], i, model_word(bs, i));
                    end
                end
            end
            if (b_addr_log.size() !== nw_b || b_wc !== 5'(nw_b) || b_done !== done_b || b_err !== err_b || b_core_rst !== done_b) begin
                fails++; $display("FAIL rand%0d_b: writes=%0d wc=%0d done=%b err=%b core_rst=%b required %0d %0d %b %b %b",
                                  it, b_addr_log.size(), b_wc, b_done, b_err, b_core_rst, nw_b, nw_b, done_b, err_b, done_b);
            end else begin
                for (int i = 0; i < nw_b; i++) begin
                    checks++;
                    if (b_data_log[i] !== model_word(bs, i)) begin
                        fails++; $display("FAIL rand%0d_b_word%0d: data=%h required %h", it, i, b_data_log[i], model_word(bs, i));
                    end
                end
            end
            checks++;
            if (a_done !== done_a || a_err !== err_a || viol !== 0) begin
                fails++; $display("FAIL rand%0d_a_status: done=%b err=%b viol=%0d required %b %b 0", it, a_done, a_err, viol, done_a, err_a);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_two_word();
        test_reset();
        test_empty();
        test_overflow();
        test_full_memory();
        test_stall();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
